// File: rtl/bp_proto_pkg.sv
// Word format and tags shared by the command dispatcher and the result packer.
// A host word is {tag[7:0], payload[7:0]}.
package bp_proto_pkg;

   localparam logic [7:0] TAG_DATA   = 8'h00;
   localparam logic [7:0] TAG_AUX    = 8'h04;
   localparam logic [7:0] TAG_STATUS = 8'hE0;

   // Pending-register slots; a lower index wins arbitration.
   localparam int NUM_SRC    = 3;
   localparam int SRC_STATUS = 0;
   localparam int SRC_DATA   = 1;
   localparam int SRC_AUX    = 2;

   typedef struct packed {
      logic [7:0] tag;
      logic [7:0] payload;
   } bp_word_t;

   function automatic bp_word_t bp_frame(input logic [7:0] tag, input logic [7:0] payload);
      bp_word_t w;
      w.tag     = tag;
      w.payload = payload;
      return w;
   endfunction

endpackage

// File: rtl/result_queue.sv
// DEPTH x 16 synchronous FIFO with (AW+1)-bit wrap pointers.
// A push while full is accepted when a pop frees the head slot in the same cycle.
module result_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        push,
   input  logic [15:0] push_data,
   input  logic        pop,
   output logic [15:0] head,
   output logic        full,
   output logic        empty
);

   logic [AW:0] wp_q, wp_d, rp_q, rp_d;
   logic [15:0] mem_q [DEPTH];
   logic        do_push, do_pop;

   always_comb begin
      empty   = (wp_q == rp_q);
      full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      wp_d    = do_push ? wp_q + 1'b1 : wp_q;
      rp_d    = do_pop  ? rp_q + 1'b1 : rp_q;
      head    = mem_q[rp_q[AW-1:0]];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   // Storage needs no reset: nothing is visible until a pointer has moved past it.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wp_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/result_packer.sv
// Frames status codes, peripheral read bytes and aux pin samples into host words
// and pushes them to the output FIFO, absorbing back-pressure in pending registers and a queue.
module result_packer #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        data_valid,
   input  logic [7:0]  data_byte,
   input  logic        aux_sample_req,
   input  logic        bp_aux0_in,
   input  logic        status_valid,
   input  logic [7:0]  status_code,
   input  logic        out_fifo_in_full,
   output logic        out_fifo_in_shift,
   output logic [15:0] out_fifo_in_data,
   output logic        overflow,
   input  logic        overflow_clear,
   output logic        busy
);

   import bp_proto_pkg::*;

   logic               sync1_q, sync2_q;
   logic [NUM_SRC-1:0] pend_valid_q, pend_valid_d;
   bp_word_t           pend_word_q [NUM_SRC];
   bp_word_t           pend_word_d [NUM_SRC];
   bp_word_t           new_word    [NUM_SRC];
   logic [NUM_SRC-1:0] strobe, drain;
   logic [1:0]         sel;
   logic               drop;
   logic               overflow_q, overflow_d;

   logic               q_push, q_pop, q_full, q_empty;
   logic [15:0]        q_head;
   bp_word_t           q_wdata;

   always_comb begin
      strobe             = '0;
      strobe[SRC_STATUS] = status_valid;
      strobe[SRC_DATA]   = data_valid;
      strobe[SRC_AUX]    = aux_sample_req;

      new_word[SRC_STATUS] = bp_frame(TAG_STATUS, status_code);
      new_word[SRC_DATA]   = bp_frame(TAG_DATA, data_byte);
      new_word[SRC_AUX]    = bp_frame(TAG_AUX, {7'b0, sync2_q});

      q_pop = !q_empty && !out_fifo_in_full;

      // Descending scan so the lowest-index valid source is the one left in sel.
      sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend_valid_q[i]) sel = 2'(i);
      end
      q_push     = (|pend_valid_q) && (!q_full || q_pop);
      q_wdata    = pend_word_q[sel];
      drain      = '0;
      drain[sel] = q_push;

      drop         = 1'b0;
      pend_valid_d = pend_valid_q;
      pend_word_d  = pend_word_q;
      for (int i = 0; i < NUM_SRC; i++) begin
         pend_valid_d[i] = (pend_valid_q[i] && !drain[i]) || strobe[i];
         if (strobe[i] && (!pend_valid_q[i] || drain[i])) pend_word_d[i] = new_word[i];
         if (strobe[i] && pend_valid_q[i] && !drain[i])   drop = 1'b1;
      end

      if (drop)                overflow_d = 1'b1;
      else if (overflow_clear) overflow_d = 1'b0;
      else                     overflow_d = overflow_q;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         pend_valid_q <= '0;
         overflow_q   <= 1'b0;
         for (int i = 0; i < NUM_SRC; i++) pend_word_q[i] <= '0;
      end else begin
         sync1_q      <= bp_aux0_in;
         sync2_q      <= sync1_q;
         pend_valid_q <= pend_valid_d;
         overflow_q   <= overflow_d;
         for (int i = 0; i < NUM_SRC; i++) pend_word_q[i] <= pend_word_d[i];
      end
   end

   result_queue #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_queue (
      .clock     (clock),
      .reset     (reset),
      .push      (q_push),
      .push_data (q_wdata),
      .pop       (q_pop),
      .head      (q_head),
      .full      (q_full),
      .empty     (q_empty)
   );

   assign out_fifo_in_shift = q_pop;
   assign out_fifo_in_data  = q_empty ? 16'h0000 : q_head;
   assign overflow          = overflow_q;
   assign busy              = (|pend_valid_q) || !q_empty;

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: a per-cycle vector table plus hand-written
// sequences for back-pressure fill, overflow clear/set priority and mid-stream reset.
module tb_result_packer;

   logic        clock = 1'b0;
   logic        reset;
   logic        data_valid, aux_sample_req, bp_aux0_in, status_valid;
   logic [7:0]  data_byte, status_code;
   logic        out_fifo_in_full, overflow_clear;
   logic        out_fifo_in_shift, overflow, busy;
   logic [15:0] out_fifo_in_data;

   int n_vec = 0;
   int n_err = 0;

   result_packer #(.DEPTH(4), .AW(2)) dut (
      .clock             (clock),
      .reset             (reset),
      .data_valid        (data_valid),
      .data_byte         (data_byte),
      .aux_sample_req    (aux_sample_req),
      .bp_aux0_in        (bp_aux0_in),
      .status_valid      (status_valid),
      .status_code       (status_code),
      .out_fifo_in_full  (out_fifo_in_full),
      .out_fifo_in_shift (out_fifo_in_shift),
      .out_fifo_in_data  (out_fifo_in_data),
      .overflow          (overflow),
      .overflow_clear    (overflow_clear),
      .busy              (busy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        sv;
      logic [7:0]  sc;
      logic        dv;
      logic [7:0]  db;
      logic        ar;
      logic        pin;
      logic        full;
      logic        oc;
      logic        e_shift;
      logic [15:0] e_data;
      logic        e_ovf;
      logic        e_busy;
   } vec_t;

   vec_t tbl [$];

   task automatic chk1(input string name, input logic got, input logic exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Advance one edge, then drop the one-cycle pulses.
   task automatic tick();
      @(posedge clock);
      #1;
      status_valid   = 1'b0;
      data_valid     = 1'b0;
      aux_sample_req = 1'b0;
      overflow_clear = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      data_valid = 1'b0; data_byte = 8'h00; aux_sample_req = 1'b0; bp_aux0_in = 1'b0;
      status_valid = 1'b0; status_code = 8'h00; out_fifo_in_full = 1'b0; overflow_clear = 1'b0;

      // Row: drive inputs, check outputs in that cycle, then the edge samples the strobes.
      //               sv  sc     dv  db     ar  pin full oc   shift data      ovf busy
      tbl.push_back('{1'b0,8'h00,1'b1,8'hA5,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h00A5,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b1,1'b1,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0, 1'b1,16'h0401,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0400,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b1,8'h12,1'b1,8'h34,1'b1,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'hE012,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0034,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0400,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b1,8'h5A,1'b0,1'b0,1'b1,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0, 1'b0,16'h0000,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0, 1'b0,16'h005A,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h005A,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b1,8'h11,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});
      tbl.push_back('{1'b0,8'h00,1'b1,8'h22,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0011,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b1,16'h0022,1'b0,1'b1});
      tbl.push_back('{1'b0,8'h00,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 1'b0,16'h0000,1'b0,1'b0});

      tick();
      tick();
      chk1("rst_shift", out_fifo_in_shift, 1'b0);
      chk16("rst_data", out_fifo_in_data, 16'h0000);
      chk1("rst_ovf", overflow, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      reset = 1'b0;
      tick();

      foreach (tbl[i]) begin
         status_valid     = tbl[i].sv;
         status_code      = tbl[i].sc;
         data_valid       = tbl[i].dv;
         data_byte        = tbl[i].db;
         aux_sample_req   = tbl[i].ar;
         bp_aux0_in       = tbl[i].pin;
         out_fifo_in_full = tbl[i].full;
         overflow_clear   = tbl[i].oc;
         #1;
         chk1($sformatf("row%0d_shift", i), out_fifo_in_shift, tbl[i].e_shift);
         chk16($sformatf("row%0d_data", i), out_fifo_in_data, tbl[i].e_data);
         chk1($sformatf("row%0d_ovf", i), overflow, tbl[i].e_ovf);
         chk1($sformatf("row%0d_busy", i), busy, tbl[i].e_busy);
         tick();
      end

      // Fill under back-pressure: 01..04 queued, 05 pending, 06/07 dropped.
      out_fifo_in_full = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         data_valid = 1'b1;
         data_byte  = 8'(k);
         tick();
         tick();
         if (k == 5) chk1("fill_ovf_after05", overflow, 1'b0);
         if (k == 6) chk1("fill_ovf_after06", overflow, 1'b1);
      end
      chk1("fill_shift_held", out_fifo_in_shift, 1'b0);
      chk16("fill_head", out_fifo_in_data, 16'h0001);
      chk1("fill_busy", busy, 1'b1);
      out_fifo_in_full = 1'b0;
      #1;
      for (int k = 1; k <= 5; k++) begin
         chk1($sformatf("drain%0d_shift", k), out_fifo_in_shift, 1'b1);
         chk16($sformatf("drain%0d_data", k), out_fifo_in_data, {8'h00, 8'(k)});
         tick();
      end
      chk1("drain_end_shift", out_fifo_in_shift, 1'b0);
      chk1("drain_end_busy", busy, 1'b0);
      chk1("drain_end_ovf", overflow, 1'b1);

      overflow_clear = 1'b1;
      tick();
      chk1("ovf_cleared", overflow, 1'b0);

      // DATA loses arbitration to STATUS, so a second data strobe is dropped while clear is asserted.
      status_valid = 1'b1; status_code = 8'hAA;
      data_valid   = 1'b1; data_byte   = 8'hBB;
      tick();
      data_valid = 1'b1; data_byte = 8'hCC; overflow_clear = 1'b1;
      tick();
      chk1("ovf_set_wins", overflow, 1'b1);
      chk1("prio_shift0", out_fifo_in_shift, 1'b1);
      chk16("prio_word0", out_fifo_in_data, 16'hE0AA);
      tick();
      chk1("prio_shift1", out_fifo_in_shift, 1'b1);
      chk16("prio_word1", out_fifo_in_data, 16'h00BB);
      tick();
      chk1("prio_done_shift", out_fifo_in_shift, 1'b0);
      chk1("prio_done_busy", busy, 1'b0);

      // Three words queued behind back-pressure, then reset between edges.
      out_fifo_in_full = 1'b1;
      status_valid = 1'b1; status_code = 8'h01;
      data_valid   = 1'b1; data_byte   = 8'h02;
      aux_sample_req = 1'b1;
      tick();
      tick();
      tick();
      tick();
      chk1("pre_rst_busy", busy, 1'b1);
      out_fifo_in_full = 1'b0;
      #1;
      chk1("pre_rst_shift", out_fifo_in_shift, 1'b1);
      chk16("pre_rst_data", out_fifo_in_data, 16'hE001);
      #1;
      reset = 1'b1;
      #1;
      chk1("async_rst_shift", out_fifo_in_shift, 1'b0);
      chk1("async_rst_busy", busy, 1'b0);
      chk16("async_rst_data", out_fifo_in_data, 16'h0000);
      chk1("async_rst_ovf", overflow, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk1($sformatf("post_rst%0d_shift", k), out_fifo_in_shift, 1'b0);
         chk1($sformatf("post_rst%0d_busy", k), busy, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
